// File: rtl/led_strand_scheduler_if.sv
// led_strand_scheduler_if: signal bundle between the strand scheduler and its host, pixel source and strand drivers
//   master modport: scheduler side (drives fetch strobes, serial lines, strand gates, status)
//   slave modport : host/pixel-source side (drives requests, lengths, pixel words, blank)
//   frame_req[4]  per-strand refresh request pulse
//   strand_len[20] 5-bit LED count per strand, strand i at [5i+4:5i]
//   pix_data[32]  pixel word, valid 1 clk after pix_req
//   blank[4]      per-strand blank request (LED_SCHED_BLANK_EN builds only)
//   pix_req/pix_sel/pix_idx  pixel fetch strobe, strand and LED index
//   sck/mosi      shared serial clock and data
//   strand_en[4]  one-hot gate of the granted strand
//   busy          scheduler not idle
//   frame_done[4] one-clk completion pulse of the finished strand
interface led_strand_scheduler_if;
    logic [3:0]  frame_req;
    logic [19:0] strand_len;
    logic [31:0] pix_data;
    logic [3:0]  blank;
    logic        pix_req;
    logic [1:0]  pix_sel;
    logic [3:0]  pix_idx;
    logic        sck;
    logic        mosi;
    logic [3:0]  strand_en;
    logic        busy;
    logic [3:0]  frame_done;
    modport master (
        input  frame_req, strand_len, pix_data, blank,
        output pix_req, pix_sel, pix_idx, sck, mosi, strand_en, busy, frame_done
    );
    modport slave (
        output frame_req, strand_len, pix_data, blank,
        input  pix_req, pix_sel, pix_idx, sck, mosi, strand_en, busy, frame_done
    );
endinterface

// File: rtl/led_strand_scheduler.sv
// led_strand_scheduler: round-robin arbiter that serialises LED frames for 4 strands over one shared sck/mosi pair
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    led_strand_scheduler_if.master (requests, lengths, pixel fetch, serial lines, strand gates, status)
//   SCK_DIV  clk cycles per sck period (even, >= 4); NSTR  number of strands (fixed at 4)
//   Optional macro LED_SCHED_BLANK_EN: when defined, blank[g] replaces fetched pixels with 32'hE0000000.
// A frame is 32 zero bits, one 32-bit word per LED, then 32 one bits. The END segment holds one extra
// sck-low clk after its last bit so the driver sees sck return low while strand_en is still asserted.
module led_strand_scheduler #(
    parameter int SCK_DIV = 64,
    parameter int NSTR    = 4
) (
    input logic              clk,
    input logic              reset,
    led_strand_scheduler_if.master bus
);
    localparam int PW = $clog2(SCK_DIV);
    typedef enum logic [2:0] {IDLE, GRANT, START, FETCH, LED, END, DONE} state_t;
    state_t            state, state_nx;
    logic [NSTR-1:0]   pending, strand_en, pick_oh, clr;
    logic [1:0]        rr_ptr, g, pick;
    logic [4:0]        len, raw;
    logic [3:0]        pix_idx;
    logic [PW-1:0]     ph;
    logic [5:0]        bitc;
    logic [31:0]       shreg, cap;
    logic              fph, again, shifting, bit_end, seg_end, more;
    assign shifting = state inside {START, LED, END};
    assign bit_end  = ph == PW'(SCK_DIV - 1);
    // END runs one clk past its 32nd bit (bitc == 32, sck low) before handing over to DONE
    assign seg_end  = shifting && (state == END ? bitc == 6'd32 : bit_end && bitc == 6'd31);
    assign more     = {1'b0, pix_idx} + 5'd1 < len;
    assign raw      = 5'(bus.strand_len >> (5 * pick));
    assign pick_oh  = NSTR'(1) << pick;
    // a request for the active strand during its frame keeps it pending past DONE
    assign clr      = state == DONE && !again ? strand_en : '0;
`ifdef LED_SCHED_BLANK_EN
    assign cap = bus.blank[g] ? 32'hE000_0000 : bus.pix_data;
`else
    logic unused_blank;
    assign unused_blank = ^bus.blank;
    assign cap = bus.pix_data;
`endif
    // first pending strand at or after rr_ptr; scanning downward lets the nearest one win
    always_comb begin
        pick = rr_ptr;
        for (int k = 3; k >= 0; k--)
            if (pending[rr_ptr + 2'(k)]) pick = rr_ptr + 2'(k);
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = |pending ? GRANT : IDLE;
            GRANT:   state_nx = START;
            START:   state_nx = seg_end ? (len != 5'd0 ? FETCH : END) : START;
            FETCH:   state_nx = fph ? LED : FETCH;
            LED:     state_nx = seg_end ? (more ? FETCH : END) : LED;
            END:     state_nx = seg_end ? DONE : END;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending   <= '0;
            rr_ptr    <= '0;
            g         <= '0;
            strand_en <= '0;
            len       <= '0;
            pix_idx   <= '0;
            ph        <= '0;
            bitc      <= '0;
            shreg     <= '0;
            fph       <= 1'b0;
            again     <= 1'b0;
        end else begin
            pending <= (pending & ~clr) | bus.frame_req;
            again   <= state == GRANT ? |(bus.frame_req & pick_oh) : again | |(bus.frame_req & strand_en);
            if (shifting) begin
                ph <= bit_end ? '0 : ph + 1'b1;
                if (bit_end) begin
                    bitc  <= bitc + 6'd1;
                    shreg <= {shreg[30:0], 1'b0};
                end
            end
            if (seg_end) begin
                ph   <= '0;
                bitc <= '0;
                if (state_nx == END) shreg <= '1;
            end
            if (state == GRANT) begin
                g         <= pick;
                strand_en <= pick_oh;
                len       <= raw > 5'd16 ? 5'd16 : raw;
                pix_idx   <= '0;
                shreg     <= '0;
            end
            if (state == FETCH) begin
                fph <= ~fph;
                if (fph) shreg <= cap;
            end
            if (state == LED && seg_end && more) pix_idx <= pix_idx + 4'd1;
            if (state == DONE) begin
                strand_en <= '0;
                rr_ptr    <= g + 2'd1;
            end
        end
    end
    assign bus.pix_req    = state == FETCH && !fph;
    assign bus.pix_sel    = g;
    assign bus.pix_idx    = pix_idx;
    assign bus.sck        = shifting && ph >= PW'(SCK_DIV / 2);
    assign bus.mosi       = shifting && shreg[31];
    assign bus.strand_en  = strand_en;
    assign bus.busy       = state != IDLE;
    assign bus.frame_done = state == DONE ? strand_en : '0;
endmodule
